// File: rtl/hs4_rx_fifo.sv
// Four-phase req/ack receiver feeding an elastic FIFO with valid/ready output.
// Define HS4_REQ_SYNC_EN to pass req through a 2-flop synchroniser.
module hs4_rx_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic                     req,
    input  logic [WIDTH-1:0]         data_in,
    output logic                     ack,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         out_data,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     full,
    output logic [CNT_W-1:0]         hs_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    typedef enum logic {IDLE, ACKHI} state_t;

    state_t               state;
    state_t               state_nx;
    logic                 req_i;
    logic                 push;
    logic                 pop;
    logic                 hs_done;
    logic [AW-1:0]        wr_ptr;
    logic [AW-1:0]        rd_ptr;
    logic [WIDTH-1:0]     mem [DEPTH];

`ifdef HS4_REQ_SYNC_EN
    logic [1:0] req_sync;

    always_ff @(posedge clk) begin
        if (!rst) req_sync <= '0;
        else      req_sync <= {req_sync[0], req};
    end

    assign req_i = req_sync[1];
`else
    assign req_i = req;
`endif

    always_comb begin
        state_nx = state;
        push     = 1'b0;
        hs_done  = 1'b0;
        unique case (state)
            IDLE: begin
                // full is the registered flag, so a same-cycle pop cannot unblock
                if (en && req_i && !full) begin
                    push     = 1'b1;
                    state_nx = ACKHI;
                end
            end
            ACKHI: begin
                if (!req_i) begin
                    hs_done  = 1'b1;
                    state_nx = IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= IDLE;
            ack      <= 1'b0;
            hs_count <= '0;
        end else begin
            state <= state_nx;
            ack   <= (state_nx == ACKHI);
            if (hs_done) hs_count <= hs_count + CNT_W'(1);
        end
    end

    assign out_valid = (level != '0);
    assign full      = (level == LW'(DEPTH));
    assign pop       = out_valid && out_ready;
    assign out_data  = out_valid ? mem[rd_ptr] : '0;

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            level <= level + LW'(push) - LW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= data_in;
    end

endmodule

// File: tb/tb_hs4_rx_fifo.sv
// Bench for hs4_rx_fifo: directed scenarios plus random traffic
// compared every cycle against a queue-based reference model.
module tb_hs4_rx_fifo;

    localparam int W  = 8;
    localparam int D  = 4;
    localparam int CW = 4;
    localparam int LW = $clog2(D) + 1;
`ifdef HS4_REQ_SYNC_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 1;
`endif

    logic          clk;
    logic          rst;
    logic          en;
    logic          req;
    logic [W-1:0]  data_in;
    logic          ack;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_data;
    logic [LW-1:0] level;
    logic          full;
    logic [CW-1:0] hs_count;

    hs4_rx_fifo #(.WIDTH(W), .DEPTH(D), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .en(en), .req(req), .data_in(data_in),
        .ack(ack), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .level(level), .full(full),
        .hs_count(hs_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_pass = 0;
    int n_tot  = 0;

    // reference model: word queue, open-handshake flag, handshake tally,
    // and the req history the receiver sees through its synchroniser
    logic [W-1:0] q[$];
    bit           open;
    int           hs;
    bit   [1:0]   rq;

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        n_tot++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic tick();
        bit reqi;
        bit pop;
        @(posedge clk);
        reqi = (LAT == 3) ? rq[1] : req;
        if (!rst) begin
            q.delete();
            open = 0;
            hs   = 0;
            rq   = '0;
        end else begin
            pop = (q.size() != 0) && out_ready;
            if (!open) begin
                if (en && reqi && q.size() < D) begin
                    q.push_back(data_in);
                    open = 1;
                end
            end else if (!reqi) begin
                open = 0;
                hs   = (hs + 1) % (1 << CW);
            end
            if (pop) void'(q.pop_front());
            rq = {rq[0], req};
        end
        #1;
        chk("ack", ack, open);
        chk("out_valid", out_valid, q.size() != 0);
        chk("out_data", out_data, q.size() != 0 ? q[0] : 8'h00);
        chk("level", level, q.size());
        chk("full", full, q.size() == D);
        chk("hs_count", hs_count, hs);
    endtask

    task automatic wait_ack(bit v, string tag);
        int t = 0;
        while (ack !== v && t < 40) begin
            tick();
            t++;
        end
        chk(tag, ack, v);
    endtask

    task automatic send(logic [W-1:0] d);
        data_in = d;
        req     = 1'b1;
        wait_ack(1'b1, "send_rise");
        req = 1'b0;
        wait_ack(1'b0, "send_fall");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int hs0;
        logic [W-1:0] exp_drain [4];
        exp_drain = '{8'h02, 8'h03, 8'h04, 8'h05};

        rst = 0; en = 0; req = 0; data_in = '0; out_ready = 0;
        q.delete(); open = 0; hs = 0; rq = '0;
        tick();
        tick();
        chk("rst_ack", ack, 0);
        chk("rst_level", level, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_data", out_data, 0);
        chk("rst_hs", hs_count, 0);
        rst = 1;
        tick();

        // single handshake latency
        en = 1; data_in = 8'hA5; req = 1;
        repeat (LAT - 1) tick();
        chk("s1_ack_early", ack, 0);
        tick();
        chk("s1_ack", ack, 1);
        chk("s1_level", level, 1);
        chk("s1_data", out_data, 8'hA5);
        req = 0;
        repeat (LAT - 1) tick();
        chk("s1_ack_hold", ack, 1);
        tick();
        chk("s1_ack_fall", ack, 0);
        chk("s1_hs", hs_count, 1);
        out_ready = 1;
        tick();
        out_ready = 0;

        // fill, blocked 5th word, pop, refill
        for (int i = 1; i <= 4; i++) send(W'(i));
        chk("s2_full", full, 1);
        data_in = 8'h05; req = 1;
        repeat (LAT + 4) tick();
        chk("s2_blocked", ack, 0);
        chk("s2_head", out_data, 8'h01);
        out_ready = 1;
        tick();
        out_ready = 0;
        tick();
        if (!ack) tick();
        chk("s2_refill_ack", ack, 1);
        chk("s2_refill_lvl", level, 4);
        req = 0;
        wait_ack(1'b0, "s2_fall");
        out_ready = 1;
        for (int i = 0; i < 4; i++) begin
            chk("s2_drain", out_data, exp_drain[i]);
            tick();
        end
        out_ready = 0;
        chk("s2_empty", out_valid, 0);

        // en gating, then en drop during ACKHI
        en = 0; data_in = 8'h3C; req = 1;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("s3_ack_off", ack, 0);
            chk("s3_lvl_off", level, 0);
        end
        hs0 = hs;
        en = 1;
        tick();
        chk("s3_en_ack", ack, 1);
        en = 0; req = 0;
        wait_ack(1'b0, "s3_fall");
        chk("s3_hs_inc", hs_count, CW'(hs0 + 1));
        en = 1;
        out_ready = 1;
        tick();
        tick();

        // back-to-back with continuous drain
        for (int i = 0; i < 6; i++) begin
            send(W'(8'h40 + i));
            chk("s4_lvl_le1", level <= 1, 1);
        end
        tick();
        tick();
        out_ready = 0;
        send(8'h77);
        data_in = 8'h78; req = 1;
        repeat (LAT - 1) tick();
        out_ready = 1;
        tick();
        out_ready = 0;
        chk("s4_pushpop_lvl", level, 1);
        chk("s4_pushpop_data", out_data, 8'h78);
        req = 0;
        wait_ack(1'b0, "s4_fall");

        // counter wrap
        out_ready = 1;
        for (int g = 0; g < 20 && hs != 15; g++) send(W'($urandom));
        chk("wrap_pre", hs_count, 15);
        send(8'h99);
        chk("wrap_zero", hs_count, 0);
        tick();
        tick();
        out_ready = 0;

        // reset in the middle of a handshake
        send(8'h11);
        send(8'h22);
        data_in = 8'h33; req = 1;
        wait_ack(1'b1, "s5_rise");
        chk("s5_lvl3", level, 3);
        rst = 0;
        tick();
        chk("s5_ack", ack, 0);
        chk("s5_lvl", level, 0);
        chk("s5_valid", out_valid, 0);
        chk("s5_hs", hs_count, 0);
        req = 0; rst = 1;
        repeat (LAT + 2) tick();

        // random traffic
        for (int c = 0; c < 500; c++) begin
            en        = ($urandom_range(0, 7) != 0);
            out_ready = $urandom_range(0, 1) != 0;
            if (!req && !ack && $urandom_range(0, 2) == 0) begin
                data_in = W'($urandom);
                req     = 1;
            end else if (req && ack && $urandom_range(0, 1) == 0) begin
                req = 0;
            end
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
